pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, successor to the fixed-field IF/ID register.
- Carries one opaque DATA_W-bit payload with a valid/ready handshake on both sides.
- Supports hazard-unit stall, branch/exception flush with bubble injection, an optional 1-entry skid buffer, and saturating stall/flush event counters.
- Instantiated between every pair of adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the payload is packed by the surrounding stage.

Parameters:
- DATA_W, 32: payload width in bits (1..256).
- SKID, 1: 1 = registered in_ready with a 1-entry skid buffer; 0 = combinational in_ready, no skid.
- RESET_DATA, 0: value of out_data after reset.
- BUBBLE_DATA, 0: value loaded into out_data on flush (NOP encoding for instruction-carrying stages).
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered payload.
- stall  in  1  hazard hold: freeze the stage.
- flush  in  1  kill all held beats and inject a bubble.
- stall_cnt  out  CNT_W  cycles with stall=1 and flush=0, saturating.
- flush_cnt  out  CNT_W  cycles with flush=1 that killed at least one valid beat, saturating.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - main_valid=0, skid_valid=0, out_data=RESET_DATA, skid data=RESET_DATA, both counters 0.
  - in_ready=0 combinationally while rst_n=0.
  - Reset mid-transfer discards everything.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- out_valid = main_valid & ~stall & ~flush (combinational mask); out_data is always the main register.
- Priority, per cycle: reset > flush > stall > normal.
- Flush:
  - Next cycle main_valid=0, skid_valid=0, out_data=BUBBLE_DATA.
  - in_ready=0 during the flush cycle, so no beat is accepted.
  - Flush with stall also asserted behaves as a flush.
- Stall (flush=0):
  - in_ready=0, out_valid=0.
  - Main and skid registers hold; no accept, no drain.
- Normal, SKID=0:
  - in_ready = ~main_valid | out_ready.
  - On accept, main loads in_data and main_valid=1.
  - On drain without accept, main_valid=0; out_data holds its last value.
  - Latency 1 cycle; throughput 1 beat/cycle.
- Normal, SKID=1:
  - in_ready = ~skid_valid (no combinational path from out_ready).
  - On accept: if main is empty or draining this cycle, load main; otherwise load skid and set skid_valid=1.
  - On drain with skid_valid=1: main loads skid, skid_valid=0.
  - Simultaneous drain, accept and skid_valid=1 cannot occur, because in_ready=0 whenever skid_valid=1.
  - Latency 1 cycle; full throughput under continuous out_ready=1.
  - Maximum occupancy is 2 beats; no overflow is possible.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Counters:
  - Increment by 1 per qualifying cycle.
  - Saturate at all-ones with no wrap.
  - Cleared only by reset.
  - A flush cycle increments flush_cnt only if main_valid or skid_valid was 1.

Decomposition:
- Shared package pipe_pkg holds the payload struct widths per stage (IF_ID_W, ID_EX_W, ...), NOP_INSTR = 32'h00000000, and the counter width default.
- One natural sub-module, sat_counter (CNT_W, inc), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset then stream: rst_n=0 for 2 cycles, then in_data=0x11,0x22,0x33 on consecutive cycles with out_ready=1 → out_data 0x11,0x22,0x33 one cycle later each, out_valid continuously 1, in_ready=1 throughout (both SKID values).
- Backpressure, SKID=1: main holds 0xA1, out_ready=0, offer 0xB2 → 0xB2 goes to skid and in_ready drops to 0 the next cycle. Set out_ready=1 → 0xA1 then 0xB2 emerge, no loss.
- Stall: main holds 0x55, stall=1 for 3 cycles with in_valid=1, in_data=0x66 → out_valid=0, in_ready=0, stall_cnt=3. After release, 0x55 appears before 0x66.
- Flush with both entries full: main 0x01, skid 0x02, flush=1 → next cycle out_valid=0, out_data=BUBBLE_DATA, flush_cnt=1. A second flush on an empty stage leaves flush_cnt=1.
- Flush and stall together while a beat is offered → treated as flush: beat not accepted, stall_cnt unchanged.
- Saturation with CNT_W=3: stall for 10 cycles → stall_cnt=7, stays 7. Synchronous reset mid-stall → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers: per-stage payload widths,
// the bubble instruction encoding and the per-cycle operating mode of a stage.
package pipe_pkg;

    localparam int IF_ID_W   = 64;
    localparam int ID_EX_W   = 128;
    localparam int EX_MEM_W  = 96;
    localparam int MEM_WB_W  = 72;
    localparam int CNT_W_DEF = 16;

    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    // Listed in priority order: a lower enumerator wins when several conditions hold.
    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_FLUSH = 2'd1,
        OP_STALL = 2'd2,
        OP_RUN   = 2'd3
    } stage_op_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: one opaque payload, valid/ready on both sides,
// hazard stall, flush with bubble injection, optional skid entry and event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = 32,
    parameter int                 SKID        = 1,
    parameter logic [DATA_W-1:0]  RESET_DATA  = '0,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int                 CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Handshake: a beat moves on a port only in a cycle where valid and ready are
    // both 1 at the rising edge; valid never depends on ready on the same port.
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    stage_op_e w_op;
    logic      w_ready_run;
    logic      w_accept;
    logic      w_drain;
    logic      w_stall_inc;
    logic      w_flush_inc;

    always_comb begin
        w_op = OP_RUN;
        if (!rst_n)     w_op = OP_RESET;
        else if (flush) w_op = OP_FLUSH;
        else if (stall) w_op = OP_STALL;
    end

    // With the skid entry, in_ready comes straight from a flop, cutting the out_ready path.
    assign w_ready_run = (SKID != 0) ? ~r_skid_valid : (~r_main_valid | out_ready);
    assign in_ready    = (w_op == OP_RUN) & w_ready_run;
    assign out_valid   = r_main_valid & ~stall & ~flush;
    assign out_data    = r_main_data;

    assign w_accept    = in_valid & in_ready;
    assign w_drain     = out_valid & out_ready;
    assign w_stall_inc = (w_op == OP_STALL);
    assign w_flush_inc = (w_op == OP_FLUSH) & (r_main_valid | r_skid_valid);

    always_ff @(posedge clk) begin
        case (w_op)
            OP_RESET: begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_main_data  <= RESET_DATA;
                r_skid_data  <= RESET_DATA;
            end
            OP_FLUSH: begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_main_data  <= BUBBLE_DATA;
            end
            OP_STALL: begin
            end
            default: begin
                if (SKID != 0) begin
                    // in_ready is low while the skid entry is full, so refill and accept never coincide.
                    if (w_drain && r_skid_valid) begin
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end else if (w_accept) begin
                        if (!r_main_valid || w_drain) begin
                            r_main_data  <= in_data;
                            r_main_valid <= 1'b1;
                        end else begin
                            r_skid_data  <= in_data;
                            r_skid_valid <= 1'b1;
                        end
                    end else if (w_drain) begin
                        r_main_valid <= 1'b0;
                    end
                end else begin
                    if (w_accept) begin
                        r_main_data  <= in_data;
                        r_main_valid <= 1'b1;
                    end else if (w_drain) begin
                        r_main_valid <= 1'b0;
                    end
                end
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (3-bit counters) and a
// no-skid instance share stimulus; drained beats are checked against queues.
module tb_pipe_stage_reg;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          en0;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          stall;
    logic          flush;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [CW-1:0] stall_cnt1, flush_cnt1, stall_cnt0, flush_cnt0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_q0[$];
    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .RESET_DATA(8'h5A), .BUBBLE_DATA(8'hEE), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .RESET_DATA(8'h5A), .BUBBLE_DATA(8'hEE), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & en0), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: bench did not finish within 100000 time units");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        exp_q.push_back(d);
    endtask

    // Scoreboard monitors: one per instance, comparing every drained beat
    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain_skid: got unexpected beat %h, expected none", out_data1);
            end else begin
                check("drain_skid", {24'h0, out_data1}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain_noskid: got unexpected beat %h, expected none", out_data0);
            end else begin
                check("drain_noskid", {24'h0, out_data0}, {24'h0, exp_q0.pop_front()});
            end
        end
    end

    initial begin
        logic [DW-1:0] stream [3];
        stream[0] = 8'h11;
        stream[1] = 8'h22;
        stream[2] = 8'h33;

        rst_n = 1'b0; in_valid = 1'b0; en0 = 1'b0; in_data = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready_skid", in_ready1, 0);
        check("rst_in_ready_noskid", in_ready0, 0);
        tick();
        check("rst_out_valid", out_valid1, 0);
        check("rst_out_data", out_data1, 8'h5A);
        check("rst_stall_cnt", stall_cnt1, 0);
        check("rst_flush_cnt", flush_cnt1, 0);

        // Reset then stream on both instances
        rst_n = 1'b1; en0 = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            push1(stream[i]);
            exp_q0.push_back(stream[i]);
            #1;
            check("stream_in_ready_skid", in_ready1, 1);
            check("stream_in_ready_noskid", in_ready0, 1);
            if (i > 0) begin
                check("stream_out_valid_skid", out_valid1, 1);
                check("stream_out_valid_noskid", out_valid0, 1);
            end
            tick();
        end
        in_valid = 1'b0; en0 = 1'b0;
        #1;
        check("stream_last_valid", out_valid1, 1);
        tick();
        check("stream_empty_skid", out_valid1, 0);
        check("stream_hold_noskid", out_data0, 8'h33);

        // Backpressure into the skid entry
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; push1(8'hA1);
        tick();
        in_data = 8'hB2; push1(8'hB2);
        #1;
        check("bp_accept_b2", in_ready1, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("bp_skid_full_ready", in_ready1, 0);
        check("bp_main_a1", out_data1, 8'hA1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_drained", out_valid1, 0);

        // Stall holds the stage and counts cycles
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; push1(8'h55);
        tick();
        stall = 1'b1; in_data = 8'h66; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready1, 0);
            check("stall_out_valid", out_valid1, 0);
            tick();
        end
        check("stall_cnt_3", stall_cnt1, 3);
        stall = 1'b0; push1(8'h66);
        #1;
        check("stall_release_ready", in_ready1, 1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("stall_cnt_hold", stall_cnt1, 3);

        // Flush with main and skid both full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; push1(8'h01);
        tick();
        in_data = 8'h02; push1(8'h02);
        tick();
        in_valid = 1'b0;
        #1;
        check("flush_pre_full", in_ready1, 0);
        flush = 1'b1;
        exp_q.delete();
        #1;
        check("flush_in_ready", in_ready1, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid1, 0);
        check("flush_bubble", out_data1, 8'hEE);
        check("flush_cnt_1", flush_cnt1, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_cnt", flush_cnt1, 1);
        out_ready = 1'b1;
        tick();
        check("flush_no_resurrect", out_valid1, 0);

        // Flush and stall together behave as flush
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        #1;
        check("fs_in_ready", in_ready1, 0);
        tick();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        #1;
        check("fs_out_valid", out_valid1, 0);
        check("fs_stall_cnt", stall_cnt1, 3);
        check("fs_flush_cnt", flush_cnt1, 1);
        tick();

        // Counter saturation, then reset mid-stall
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h99; push1(8'h99);
        tick();
        in_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("sat_stall_7", stall_cnt1, 7);
        tick();
        check("sat_stall_stay", stall_cnt1, 7);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_out_valid", out_valid1, 0);
        check("midrst_out_data", out_data1, 8'h5A);
        check("midrst_stall_cnt", stall_cnt1, 0);
        check("midrst_flush_cnt", flush_cnt1, 0);
        check("midrst_in_ready", in_ready1, 0);
        rst_n = 1'b1; stall = 1'b0; out_ready = 1'b1;
        #1;
        check("post_rst_out_valid", out_valid1, 0);
        check("post_rst_in_ready", in_ready1, 1);
        tick();
        tick();

        check("queue_empty_skid", exp_q.size(), 0);
        check("queue_empty_noskid", exp_q0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
